// File: rtl/vespa_dft_pkg.sv
// Shared types and constants for the VESPA DFT pulse sequencer.
// Includes the FSM state encoding, feedback sample levels and the burst configuration record.
package vespa_dft_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int unsigned DFT_WID_W = 8;
    localparam int unsigned DFT_CNT_W = 8;

    // Expected generator level on the last cycle of each phase.
    // The high sample only means something once the pulse has had two cycles to propagate.
    localparam logic        CHK_HIGH_LEVEL = 1'b1;
    localparam logic        CHK_LOW_LEVEL  = 1'b0;
    localparam int unsigned CHK_MIN_WIDTH  = 2;

    typedef struct packed {
        logic [DFT_WID_W-1:0] width;
        logic [DFT_WID_W-1:0] gap;
        logic [DFT_CNT_W-1:0] count;
    } cfg_t;

endpackage

// File: rtl/vespa_dft_phase_cnt.sv
// Loadable down-counter timing the HIGH and LOW phases.
// The zero flag marks the last cycle of the current phase.
module vespa_dft_phase_cnt
    import vespa_dft_pkg::*;
#(
    parameter int W = DFT_WID_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/vespa_dft_pulse_seq.sv
// Burst sequencer for the VESPA DFT pulse generator.
// Drives start/stop for N pulses of width W and gap G, and checks the fed-back pulse.
module vespa_dft_pulse_seq
    import vespa_dft_pkg::*;
#(
    parameter int WID_W  = DFT_WID_W,
    parameter int CNT_W  = DFT_CNT_W,
    parameter int CHK_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [WID_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic             start,
    output logic             stop,
    input  logic             pulse_fb,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_o,
    output logic [CNT_W-1:0] pulses_done
);

    localparam logic [WID_W-1:0] W_ONE = {{(WID_W-1){1'b0}}, 1'b1};

    state_t           state_r, next_state_s;
    logic [WID_W-1:0] w_r, g_r;
    logic [CNT_W-1:0] n_r, pulses_done_r;
    logic             start_r, stop_r, cfg_ready_r, busy_r, done_r, aborted_r, err_r;
    logic             accept_s, abort_s, last_pulse_s, phase_last_s, chk_fail_s;
    logic             load_s;
    logic [WID_W-1:0] load_val_s;

    assign accept_s     = cfg_valid && cfg_ready_r;
    assign abort_s      = abort && ((state_r == ARM) || (state_r == HIGH) || (state_r == LOW));
    assign last_pulse_s = (({1'b0, pulses_done_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, n_r});

    vespa_dft_phase_cnt #(.W(WID_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (1'b1),
        .zero     (phase_last_s)
    );

    // Next-state selection; abort always wins over phase completion.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = (cfg_count == {CNT_W{1'b0}}) ? DONE : ARM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARM:  next_state_s = abort_s ? DONE : HIGH;
            HIGH: begin
                if (abort_s) begin
                    next_state_s = DONE;
                end else if (phase_last_s) begin
                    next_state_s = last_pulse_s ? DONE : LOW;
                end else begin
                    next_state_s = HIGH;
                end
            end
            LOW: begin
                if (abort_s) begin
                    next_state_s = DONE;
                end else if (phase_last_s) begin
                    next_state_s = HIGH;
                end else begin
                    next_state_s = LOW;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Phase counter reload on entry to HIGH or LOW.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = {WID_W{1'b0}};
        if ((next_state_s == HIGH) && (state_r != HIGH)) begin
            load_s     = 1'b1;
            load_val_s = w_r - W_ONE;
        end else if ((next_state_s == LOW) && (state_r != LOW)) begin
            load_s     = 1'b1;
            load_val_s = g_r - W_ONE;
        end else begin
            load_s     = 1'b0;
        end
    end

    // Feedback level check on the final cycle of each un-aborted phase.
    always_comb begin
        chk_fail_s = 1'b0;
        if ((CHK_EN != 0) && phase_last_s && !abort_s) begin
            case (state_r)
                HIGH:    chk_fail_s = (w_r >= WID_W'(CHK_MIN_WIDTH)) && (pulse_fb != CHK_HIGH_LEVEL);
                LOW:     chk_fail_s = (pulse_fb != CHK_LOW_LEVEL);
                default: chk_fail_s = 1'b0;
            endcase
        end else begin
            chk_fail_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Moore outputs registered from the next state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r     <= 1'b0;
            stop_r      <= 1'b1;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            start_r     <= (next_state_s == HIGH);
            stop_r      <= !((next_state_s == ARM) || (next_state_s == HIGH));
            cfg_ready_r <= (next_state_s == IDLE);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (next_state_s == DONE);
        end
    end

    // Burst configuration, pulse counter and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_r           <= {WID_W{1'b0}};
            g_r           <= {WID_W{1'b0}};
            n_r           <= {CNT_W{1'b0}};
            pulses_done_r <= {CNT_W{1'b0}};
            aborted_r     <= 1'b0;
            err_r         <= 1'b0;
        end else if (accept_s) begin
            w_r           <= (cfg_width == {WID_W{1'b0}}) ? W_ONE : cfg_width;
            g_r           <= (cfg_gap == {WID_W{1'b0}}) ? W_ONE : cfg_gap;
            n_r           <= cfg_count;
            pulses_done_r <= {CNT_W{1'b0}};
            aborted_r     <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            if (abort_s) begin
                aborted_r <= 1'b1;
            end
            if ((state_r == HIGH) && phase_last_s && !abort_s &&
                (pulses_done_r != {CNT_W{1'b1}})) begin
                pulses_done_r <= pulses_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (chk_fail_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign start       = start_r;
    assign stop        = stop_r;
    assign cfg_ready   = cfg_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign aborted     = aborted_r;
    assign err_o       = err_r;
    assign pulses_done = pulses_done_r;

endmodule

// File: tb/tb_vespa_dft_pulse_seq.sv
// Directed bench for vespa_dft_pulse_seq with hand-computed per-cycle traces.
// The generator is modelled as start delayed one cycle, or as a constant level.
module tb_vespa_dft_pulse_seq;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_width;
    logic [7:0] cfg_gap;
    logic [7:0] cfg_count;
    logic       abort;
    logic       start;
    logic       stop;
    logic       pulse_fb;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err_o;
    logic [7:0] pulses_done;

    logic fb_d;
    logic fb_follow;
    logic fb_level;

    int checks   = 0;
    int failures = 0;

    vespa_dft_pulse_seq dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_width   (cfg_width),
        .cfg_gap     (cfg_gap),
        .cfg_count   (cfg_count),
        .abort       (abort),
        .start       (start),
        .stop        (stop),
        .pulse_fb    (pulse_fb),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .err_o       (err_o),
        .pulses_done (pulses_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) fb_d <= start;
    assign pulse_fb = fb_follow ? fb_d : fb_level;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] w, input logic [7:0] g, input logic [7:0] c);
        cfg_width = w;
        cfg_gap   = g;
        cfg_count = c;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        rst = 1'b1;
        repeat (2) step();
        obs = {start, stop, cfg_ready, busy, done, aborted, err_o, pulses_done};
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_in: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        end
        rst = 1'b0;
        step();
        obs = {start, stop, cfg_ready, busy, done, aborted, err_o, pulses_done};
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_out: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_basic();
        logic [9:0]  st_v, sp_v, bz_v, dn_v;
        logic [11:0] fin;
        fb_follow = 1'b1;
        send_cfg(8'd3, 8'd2, 8'd2);
        for (int k = 0; k < 10; k++) begin
            st_v[9-k] = start;
            sp_v[9-k] = stop;
            bz_v[9-k] = busy;
            dn_v[9-k] = done;
            step();
        end
        checks++;
        if (st_v !== 10'b0111001110) begin
            failures++;
            $display("FAIL basic_start: got %b expected %b", st_v, 10'b0111001110);
        end
        checks++;
        if (sp_v !== 10'b0000110001) begin
            failures++;
            $display("FAIL basic_stop: got %b expected %b", sp_v, 10'b0000110001);
        end
        checks++;
        if (bz_v !== 10'b1111111111) begin
            failures++;
            $display("FAIL basic_busy: got %b expected %b", bz_v, 10'b1111111111);
        end
        checks++;
        if (dn_v !== 10'b0000000001) begin
            failures++;
            $display("FAIL basic_done: got %b expected %b", dn_v, 10'b0000000001);
        end
        fin = {busy, cfg_ready, pulses_done, err_o, aborted};
        checks++;
        if (fin !== {1'b0, 1'b1, 8'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_status: got %b expected %b", fin, {1'b0, 1'b1, 8'd2, 1'b0, 1'b0});
        end
    endtask

    task automatic test_empty();
        logic [2:0] dn_v, bz_v;
        logic       st_any;
        st_any = 1'b0;
        send_cfg(8'd5, 8'd5, 8'd0);
        for (int k = 0; k < 3; k++) begin
            dn_v[2-k] = done;
            bz_v[2-k] = busy;
            st_any    = st_any | start;
            step();
        end
        checks++;
        if (dn_v !== 3'b100) begin
            failures++;
            $display("FAIL empty_done: got %b expected %b", dn_v, 3'b100);
        end
        checks++;
        if (bz_v !== 3'b100) begin
            failures++;
            $display("FAIL empty_busy: got %b expected %b", bz_v, 3'b100);
        end
        checks++;
        if (st_any !== 1'b0) begin
            failures++;
            $display("FAIL empty_start: got %b expected %b", st_any, 1'b0);
        end
        checks++;
        if (pulses_done !== 8'd0) begin
            failures++;
            $display("FAIL empty_count: got %0d expected %0d", pulses_done, 8'd0);
        end
    endtask

    task automatic test_zero_width();
        logic [6:0] st_v, dn_v;
        fb_follow = 1'b1;
        send_cfg(8'd0, 8'd0, 8'd3);
        for (int k = 0; k < 7; k++) begin
            st_v[6-k] = start;
            dn_v[6-k] = done;
            step();
        end
        checks++;
        if (st_v !== 7'b0101010) begin
            failures++;
            $display("FAIL zw_start: got %b expected %b", st_v, 7'b0101010);
        end
        checks++;
        if (dn_v !== 7'b0000001) begin
            failures++;
            $display("FAIL zw_done: got %b expected %b", dn_v, 7'b0000001);
        end
        checks++;
        if ({busy, pulses_done} !== {1'b0, 8'd3}) begin
            failures++;
            $display("FAIL zw_count: got %b expected %b", {busy, pulses_done}, {1'b0, 8'd3});
        end
    endtask

    task automatic test_abort();
        logic [11:0] obs;
        logic [9:0]  fin;
        fb_follow = 1'b1;
        send_cfg(8'd4, 8'd2, 8'd5);
        repeat (8) step();
        checks++;
        if ({start, pulses_done} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL abort_pre: got %b expected %b", {start, pulses_done}, {1'b1, 8'd1});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        obs = {start, stop, done, aborted, pulses_done};
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL abort_done: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 1'b1, 8'd1});
        end
        step();
        fin = {busy, aborted, pulses_done};
        checks++;
        if (fin !== {1'b0, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL abort_sticky: got %b expected %b", fin, {1'b0, 1'b1, 8'd1});
        end
    endtask

    task automatic test_fb_err();
        logic [10:0] obs;
        fb_follow = 1'b0;
        fb_level  = 1'b0;
        send_cfg(8'd4, 8'd1, 8'd1);
        repeat (6) step();
        obs = {err_o, aborted, busy, pulses_done};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL fb_err_set: got %b expected %b", obs, {1'b1, 1'b0, 1'b0, 8'd1});
        end
        fb_follow = 1'b1;
        send_cfg(8'd2, 8'd1, 8'd0);
        checks++;
        if ({err_o, done} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fb_err_clear: got %b expected %b", {err_o, done}, {1'b0, 1'b1});
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [11:0] obs;
        logic [3:0]  rdy_v, bz_v;
        fb_follow = 1'b1;
        send_cfg(8'd4, 8'd2, 8'd3);
        repeat (2) step();
        checks++;
        if (start !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got %b expected %b", start, 1'b1);
        end
        rst = 1'b1;
        #1;
        obs = {start, stop, busy, cfg_ready, pulses_done};
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL rstmid_async: got %b expected %b", obs, {1'b0, 1'b1, 1'b0, 1'b1, 8'd0});
        end
        step();
        rst = 1'b0;
        step();
        send_cfg(8'd2, 8'd1, 8'd1);
        cfg_width = 8'd7;
        cfg_gap   = 8'd7;
        cfg_count = 8'd0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rdy_v[3-k] = cfg_ready;
            bz_v[3-k]  = busy;
            step();
        end
        checks++;
        if ({rdy_v, bz_v} !== {4'b0000, 4'b1111}) begin
            failures++;
            $display("FAIL busy_block: got %b expected %b", {rdy_v, bz_v}, {4'b0000, 4'b1111});
        end
        checks++;
        if ({cfg_ready, busy, done, pulses_done} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL busy_idle: got %b expected %b", {cfg_ready, busy, done, pulses_done}, {1'b1, 1'b0, 1'b0, 8'd1});
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({done, pulses_done} !== {1'b1, 8'd0}) begin
            failures++;
            $display("FAIL busy_accept: got %b expected %b", {done, pulses_done}, {1'b1, 8'd0});
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_width = 8'd0;
        cfg_gap   = 8'd0;
        cfg_count = 8'd0;
        abort     = 1'b0;
        fb_follow = 1'b0;
        fb_level  = 1'b0;
        test_reset();
        test_basic();
        test_empty();
        test_zero_width();
        test_abort();
        test_fb_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
